ff_rx_fifo: RTL and testbench
=============================

# ff_rx_fifo

Receiving end of the valid-only streaming interface driven by `ff`. The interface carries no backpressure, so this block captures every `valid_i` beat into a small show-ahead FIFO and re-presents the data to a downstream consumer through a ready/valid handshake. Beats that arrive when no slot can be freed are dropped, and the drop is flagged with a sticky overflow indicator. It sits at the consumer side of any `ff` pipeline stage, or chain of stages, in the design.

## Interface
- `SIZE`, 32, data width in bits; must match the upstream `ff` instance.
- `DEPTH`, 4, number of FIFO entries; power of two, at least 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid_i`  input  1  upstream beat present this cycle; one beat per cycle with `valid_i`=1.
- `data_i`  input  SIZE  upstream data, sampled when `valid_i`=1.
- `ready_i`  input  1  downstream can accept `data_o` this cycle.
- `data_o`  output  SIZE  head-of-FIFO word, valid when `valid_o`=1.
- `valid_o`  output  1  FIFO non-empty.
- `count_o`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_o`  output  1  sticky: at least one beat was dropped since reset.

## Operation
- Storage:
  - Register array `mem[0:DEPTH-1]` of SIZE bits.
  - Read and write pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter `count`.
- Pop:
  - Occurs when `valid_o && ready_i`.
  - Read pointer advances by one.
- Push:
  - Occurs when `valid_i && (count < DEPTH || pop)`.
  - `mem[wr_ptr] <= data_i`; write pointer advances by one.
- Drop:
  - Occurs when `valid_i && count == DEPTH && !pop`.
  - Nothing is written; `overflow_o` sets to 1 and holds until reset.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Outputs:
  - `valid_o` = (`count` != 0).
  - `data_o` = `mem[rd_ptr]`, combinational from registered state (show-ahead).
  - `count_o` = `count`.
  - `data_o` is don't-care when `valid_o`=0, but must not be X after reset (array cleared to 0).
- `data_i` is ignored when `valid_i`=0.
- `ready_i` is ignored when `valid_o`=0; no pop occurs.
- No bypass path: a beat pushed into an empty FIFO is not visible on `data_o` in the same cycle.

## Timing
- Reset (asynchronous assert, deassertion synchronous to `clk` by the system):
  - `valid_o`=0, `count_o`=0, `overflow_o`=0, `data_o`=0.
  - Pointers = 0; `mem` cleared to 0.
- Latency: beat with `valid_i`=1 in cycle N appears on `data_o`/`valid_o` in cycle N+1 when the FIFO was empty. Minimum latency is one cycle, matching `ff`.
- Throughput: one push and one pop per cycle sustained; with `ready_i` held at 1, the FIFO never exceeds occupancy 1.
- Full with simultaneous push and pop: both occur, count stays DEPTH, no drop, `overflow_o` unchanged.
- Empty with simultaneous `valid_i` and `ready_i`: push only (no pop since `valid_o`=0); count becomes 1.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or duplicate; ordering is strictly FIFO.
- Reset mid-operation: contents discarded; outputs reach reset values asynchronously, without waiting for a `clk` edge. The first `valid_i` beat after reset release is accepted normally.
- Overflow flag: updates at the edge of the dropping cycle; visible from cycle N+1.

## Test plan
- Reset then single beat, `ready_i`=0: push 0xDEADBEEF in cycle 1 -> cycle 2 shows `valid_o`=1, `data_o`=0xDEADBEEF, `count_o`=1; asserting `ready_i` in cycle 3 -> cycle 4 shows `valid_o`=0, `count_o`=0.
- Fill and overflow, DEPTH=4, `ready_i`=0: push 1,2,3,4,5 in consecutive cycles -> `count_o`=4, `overflow_o`=1 from the cycle after beat 5; draining yields 1,2,3,4 and never 5.
- Full with simultaneous push and pop: FIFO holds 1..4; `valid_i`=1 with `data_i`=9 and `ready_i`=1 in the same cycle -> `overflow_o` stays 0, `count_o`=4, drain order 2,3,4,9.
- Streaming with wrap: 10 consecutive beats 0x10..0x19 with `ready_i`=1 -> each appears on `data_o` one cycle after input, in order; `count_o` ≤1 throughout.
- Random `valid_i`/`ready_i` at 50% each for 2000 cycles against a scoreboard queue -> output order matches input order; `count_o` equals scoreboard depth every cycle; `overflow_o` asserts exactly when the model drops.
- Asynchronous reset mid-stream with `count_o`=3 and `overflow_o`=1 -> `valid_o`, `count_o` and `overflow_o` go to 0 before the next `clk` edge; a push of 0x55 after release is read back as 0x55.

Source files
------------

// File: rtl/ff_rx_fifo.sv
// ff_rx_fifo: receiving end of a valid-only stream.
// Captures every upstream beat into a small show-ahead FIFO and re-presents
// it through a ready/valid handshake. Beats arriving when no slot can be
// freed are dropped and flagged by a sticky overflow bit.
module ff_rx_fifo #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [SIZE-1:0]          data_i,
    input  logic                     ready_i,
    output logic [SIZE-1:0]          data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [SIZE-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // FIFO can still accept a beat when the consumer is taking one.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == FULL_COUNT);
        w_pop   = !w_empty && ready_i;
        w_push  = valid_i && (!w_full || w_pop);
        w_drop  = valid_i && w_full && !w_pop;
    end

    // Storage array: written at the write pointer on every accepted beat.
    // NOTE: the array is cleared in reset so data_o is never X after reset;
    // that makes it flops rather than a RAM macro, which is fine at this depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: set by any dropped beat, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Show-ahead outputs driven straight from registered state; there is no
    // bypass, so a beat into an empty FIFO appears one cycle later.
    always_comb begin
        data_o     = r_mem[r_rd_ptr];
        valid_o    = !w_empty;
        count_o    = r_count;
        overflow_o = r_overflow;
    end

endmodule

// File: tb/tb_ff_rx_fifo.sv
// Testbench for ff_rx_fifo: queue-based reference model compared on every
// falling edge, plus directed scenarios with literal expectations.
module tb_ff_rx_fifo;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    logic                   valid_i;
    logic [SIZE-1:0]        data_i;
    logic                   ready_i;
    logic [SIZE-1:0]        data_o;
    logic                   valid_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [SIZE-1:0] m_q [$];
    logic            m_ovf;

    ff_rx_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most DEPTH words; pop first frees a slot.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            int  sz;
            bit  pop;
            bit  push;
            sz   = m_q.size();
            pop  = (sz != 0) && ready_i;
            push = valid_i && ((sz < DEPTH) || pop);
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(data_i);
            if (valid_i && !push) m_ovf = 1'b1;
        end
    end

    // Compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("valid_o", 64'(valid_o), 64'(m_q.size() != 0));
            check("count_o", 64'(count_o), 64'(m_q.size()));
            check("overflow_o", 64'(overflow_o), 64'(m_ovf));
            if (m_q.size() != 0) begin
                check("data_o", 64'(data_o), 64'(m_q[0]));
            end
        end
    end

    // One clock cycle with the given inputs; returns #1 after the edge.
    task automatic drive(input logic v, input logic [SIZE-1:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        reset   = 1'b1;
        #1;
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst count_o", 64'(count_o), 64'd0);
        check("rst overflow_o", 64'(overflow_o), 64'd0);
        check("rst data_o", 64'(data_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        #2;
        do_reset();

        // Single beat, then pop.
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        check("single valid_o", 64'(valid_o), 64'd1);
        check("single data_o", 64'(data_o), 64'hDEADBEEF);
        check("single count_o", 64'(count_o), 64'd1);
        drive(1'b0, 32'h0, 1'b0);
        check("single hold data_o", 64'(data_o), 64'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b1);
        check("single popped valid_o", 64'(valid_o), 64'd0);
        check("single popped count_o", 64'(count_o), 64'd0);

        // Fill and overflow.
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, SIZE'(i), 1'b0);
        check("fill count_o", 64'(count_o), 64'd4);
        check("fill overflow_o", 64'(overflow_o), 64'd0);
        drive(1'b1, 32'd5, 1'b0);
        check("drop count_o", 64'(count_o), 64'd4);
        check("drop overflow_o", 64'(overflow_o), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain data_o", 64'(data_o), 64'(i));
            drive(1'b0, 32'h0, 1'b1);
        end
        check("drained valid_o", 64'(valid_o), 64'd0);
        check("drained overflow_o", 64'(overflow_o), 64'd1);

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, SIZE'(i), 1'b0);
        drive(1'b1, 32'd9, 1'b1);
        check("full pp count_o", 64'(count_o), 64'd4);
        check("full pp overflow_o", 64'(overflow_o), 64'd0);
        begin
            logic [SIZE-1:0] exp_order [4];
            exp_order = '{32'd2, 32'd3, 32'd4, 32'd9};
            for (int i = 0; i < 4; i++) begin
                check("full pp drain", 64'(data_o), 64'(exp_order[i]));
                drive(1'b0, 32'h0, 1'b1);
            end
        end
        check("full pp empty", 64'(valid_o), 64'd0);

        // Streaming with wrap-around.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, SIZE'(32'h10 + i), 1'b1);
            check("stream data_o", 64'(data_o), 64'(32'h10 + i));
            check("stream count_o", 64'(count_o), 64'd1);
        end
        drive(1'b0, 32'h0, 1'b1);
        check("stream end valid_o", 64'(valid_o), 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), SIZE'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, SIZE'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        check("pre-reset count_o", 64'(count_o), 64'd3);
        check("pre-reset overflow_o", 64'(overflow_o), 64'd1);
        ready_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async valid_o", 64'(valid_o), 64'd0);
        check("async count_o", 64'(count_o), 64'd0);
        check("async overflow_o", 64'(overflow_o), 64'd0);
        check("async data_o", 64'(data_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h55, 1'b0);
        check("post-reset data_o", 64'(data_o), 64'h55);
        check("post-reset count_o", 64'(count_o), 64'd1);
        drive(1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
